// File: rtl/md5_pkg.sv
// Shared MD5 types and constants: padder state encoding and block geometry.
package md5_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_PAD80 = 2'd1,
    ST_LEN   = 2'd2,
    ST_EMIT  = 2'd3
  } pad_st_t;

  localparam logic [7:0] MD5_PAD_BYTE  = 8'h80;
  localparam int         MD5_LEN_POS   = 56;
  localparam int         MD5_BLK_WORDS = 16;
  localparam int         MD5_BLK_BYTES = 64;

endpackage

// File: rtl/md5_byte_lane_wr.sv
// Byte-to-word lane decoder: maps a buffer byte position to its word, lane
// enable and the byte shifted into little-endian lane position.
module md5_byte_lane_wr
  import md5_pkg::*;
(
  input  logic [5:0]                         pos_i,
  input  logic [7:0]                         byte_i,
  output logic [$clog2(MD5_BLK_WORDS)-1:0]   word_idx_o,
  output logic [3:0]                         be_o,
  output logic [31:0]                        wdata_o
);

  assign word_idx_o = pos_i[5:2];
  assign wdata_o    = {24'h0, byte_i} << {pos_i[1:0], 3'b000};

  always_comb begin
    be_o = '0;
    be_o[pos_i[1:0]] = 1'b1;
  end

endmodule

// File: rtl/md5_block_padder.sv
// MD5 byte-stream padder: packs bytes little-endian into 512-bit blocks and
// appends 0x80, zero fill and the 64-bit message bit length.
module md5_block_padder
  import md5_pkg::*;
#(
  parameter int n     = 32,
  parameter int LEN_W = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [7:0]                         s_data_i,
  input  logic                               s_valid_i,
  input  logic                               s_last_i,
  output logic                               s_ready_o,
  output logic [0:MD5_BLK_WORDS-1][n-1:0]    blk_o,
  output logic                               blk_valid_o,
  input  logic                               blk_ready_i,
  output logic                               blk_last_o,
  output pad_st_t                            st_o
);

  pad_st_t                          st_q, st_d;
  pad_st_t                          ret_q, ret_d;
  logic                             fin_q, fin_d;
  logic [6:0]                       pos_q, pos_d;
  logic [LEN_W-1:0]                 bitlen_q, bitlen_d;
  logic [0:MD5_BLK_WORDS-1][n-1:0]  buf_q, buf_d;

  logic [7:0]                         lane_byte;
  logic [$clog2(MD5_BLK_WORDS)-1:0]   lane_idx;
  logic [3:0]                         lane_be;
  logic [31:0]                        lane_wdata;
  logic [31:0]                        lane_mask;
  logic [63:0]                        len64;

  // PAD80 reuses the same lane writer as FILL, just with the marker byte.
  assign lane_byte = (st_q == ST_PAD80) ? MD5_PAD_BYTE : s_data_i;

  md5_byte_lane_wr u_lane (
    .pos_i      (pos_q[5:0]),
    .byte_i     (lane_byte),
    .word_idx_o (lane_idx),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata)
  );

  assign lane_mask = {{8{lane_be[3]}}, {8{lane_be[2]}}, {8{lane_be[1]}}, {8{lane_be[0]}}};
  assign len64     = 64'(bitlen_q);

  assign s_ready_o   = (st_q == ST_FILL);
  assign blk_valid_o = (st_q == ST_EMIT);
  assign blk_last_o  = (st_q == ST_EMIT) && fin_q;
  assign blk_o       = buf_q;
  assign st_o        = st_q;

  always_comb begin
    st_d     = st_q;
    ret_d    = ret_q;
    fin_d    = fin_q;
    pos_d    = pos_q;
    bitlen_d = bitlen_q;
    buf_d    = buf_q;
    case (st_q)
      ST_FILL: begin
        if (s_valid_i) begin
          buf_d[lane_idx] = (buf_q[lane_idx] & ~lane_mask) | lane_wdata;
          pos_d    = pos_q + 7'd1;
          bitlen_d = bitlen_q + LEN_W'(8);
          if (pos_d == 7'(MD5_BLK_BYTES)) begin
            st_d  = ST_EMIT;
            fin_d = 1'b0;
            ret_d = s_last_i ? ST_PAD80 : ST_FILL;
          end else if (s_last_i) begin
            st_d = ST_PAD80;
          end
        end
      end
      ST_PAD80: begin
        buf_d[lane_idx] = (buf_q[lane_idx] & ~lane_mask) | lane_wdata;
        pos_d = pos_q + 7'd1;
        if (pos_d <= 7'(MD5_LEN_POS)) begin
          st_d = ST_LEN;
        end else begin
          st_d  = ST_EMIT;
          fin_d = 1'b0;
          ret_d = ST_LEN;
        end
      end
      ST_LEN: begin
        buf_d[14] = len64[31:0];
        buf_d[15] = len64[63:32];
        st_d  = ST_EMIT;
        fin_d = 1'b1;
        ret_d = ST_FILL;
      end
      ST_EMIT: begin
        // Clearing on handshake is what provides the zero fill of the next block.
        if (blk_ready_i) begin
          buf_d = '0;
          pos_d = '0;
          if (fin_q) bitlen_d = '0;
          st_d = ret_q;
        end
      end
      default: st_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q     <= ST_FILL;
      ret_q    <= ST_FILL;
      fin_q    <= 1'b0;
      pos_q    <= '0;
      bitlen_q <= '0;
      buf_q    <= '0;
    end else begin
      st_q     <= st_d;
      ret_q    <= ret_d;
      fin_q    <= fin_d;
      pos_q    <= pos_d;
      bitlen_q <= bitlen_d;
      buf_q    <= buf_d;
    end
  end

endmodule

// File: tb/tb_md5_block_padder.sv
// Bench for md5_block_padder: directed test-plan scenarios plus random
// messages, checked against a padding model built from whole messages.
module tb_md5_block_padder;
  import md5_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic                clk;
  logic                rst_i;
  logic [7:0]          s_data_i;
  logic                s_valid_i;
  logic                s_last_i;
  logic                s_ready_o;
  logic [0:15][31:0]   blk_o;
  logic                blk_valid_o;
  logic                blk_ready_i;
  logic                blk_last_o;
  pad_st_t             st_o;

  int n_assert = 0;
  int n_fail   = 0;
  int bp_mode  = 0;  // 0: always ready, 1: random ready, 2: hold ready low

  logic [512:0] exp_q[$];
  logic [512:0] last_blk;
  logic [512:0] prev_blk;
  logic         have_prev = 1'b0;

  md5_block_padder dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_last_i    (s_last_i),
    .s_ready_o   (s_ready_o),
    .blk_o       (blk_o),
    .blk_valid_o (blk_valid_o),
    .blk_ready_i (blk_ready_i),
    .blk_last_o  (blk_last_o),
    .st_o        (st_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [512:0] got, input logic [512:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [512:0] cur_blk();
    logic [512:0] r;
    r = '0;
    r[512] = blk_last_o;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = blk_o[k];
    return r;
  endfunction

  // Reference: pad the whole message as a byte array, then slice into blocks.
  task automatic model_push(input bq_t msg);
    bq_t          p;
    logic [63:0]  bits;
    logic [512:0] e;
    int           nblk;
    p = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 0; i < 8; i++) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e = '0;
      for (int j = 0; j < 64; j++) e[8*j +: 8] = p[64*b + j];
      e[512] = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  // ---------------- block-side monitor / scoreboard ----------------
  always begin
    @(negedge clk);
    #1;
    if (rst_i) begin
      blk_ready_i = 1'b0;
      have_prev   = 1'b0;
    end else begin
      if (have_prev && blk_valid_o) chk("blk_stable", cur_blk(), prev_blk);
      if (blk_valid_o) chk("s_ready_in_emit", 513'(s_ready_o), 513'(0));
      case (bp_mode)
        0:       blk_ready_i = 1'b1;
        1:       blk_ready_i = 1'($urandom_range(0, 1));
        default: blk_ready_i = 1'b0;
      endcase
      if (blk_valid_o && blk_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_blk", cur_blk(), 513'(0));
        end else begin
          chk("blk_data", cur_blk(), exp_q[0]);
          void'(exp_q.pop_front());
        end
        last_blk  = cur_blk();
        have_prev = 1'b0;
      end else if (blk_valid_o) begin
        prev_blk  = cur_blk();
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    s_data_i  = d;
    s_last_i  = l;
    s_valid_i = 1'b1;
    n = 0;
    while (!s_ready_o && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("drv_timeout", 513'(n), 513'(0));
    @(negedge clk);
  endtask

  task automatic send_msg(input bq_t msg, input bit mark_last, input int max_gap);
    int g;
    if (mark_last) model_push(msg);
    for (int i = 0; i < msg.size(); i++) begin
      if (max_gap > 0) begin
        g = $urandom_range(0, max_gap);
        if (g > 0) begin
          s_valid_i = 1'b0;
          repeat (g) @(negedge clk);
        end
      end
      send_byte(msg[i], mark_last && (i == msg.size() - 1));
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!blk_valid_o && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("drain_empty", 513'(exp_q.size()), 513'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i     = 1'b1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    exp_q.delete();
    chk("rst_s_ready",   513'(s_ready_o),   513'(1));
    chk("rst_blk_valid", 513'(blk_valid_o), 513'(0));
    chk("rst_blk_last",  513'(blk_last_o),  513'(0));
    chk("rst_blk_zero",  513'(blk_o),       513'(0));
    chk("rst_state",     513'(st_o),        513'(ST_FILL));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bq_t          msg;
    int           cyc;
    logic [512:0] abc_blk;
    logic [512:0] snap;

    rst_i = 1'b1; s_valid_i = 1'b0; s_last_i = 1'b0; s_data_i = 8'h00; blk_ready_i = 1'b0;
    do_reset();

    // "abc", no backpressure
    bp_mode = 0;
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg, 1, 0);
    wait_valid(cyc);
    chk("abc_latency", 513'(cyc), 513'(3));
    drain();
    abc_blk = last_blk;
    chk("abc_w0",   513'(last_blk[31:0]),    513'(32'h80636261));
    chk("abc_mid",  513'(last_blk[447:32]),  513'(0));
    chk("abc_w14",  513'(last_blk[479:448]), 513'(32'h00000018));
    chk("abc_w15",  513'(last_blk[511:480]), 513'(0));
    chk("abc_last", 513'(last_blk[512]),     513'(1));

    // 56 x 'a'
    msg.delete();
    repeat (56) msg.push_back(8'h61);
    send_msg(msg, 1, 0);
    wait_valid(cyc);
    chk("a56_latency",  513'(cyc), 513'(2));
    chk("a56_first_nl", 513'(blk_last_o), 513'(0));
    drain();
    chk("a56_w14", 513'(last_blk[479:448]), 513'(32'h000001C0));

    // 64 x 'a'
    msg.delete();
    repeat (64) msg.push_back(8'h61);
    send_msg(msg, 1, 0);
    wait_valid(cyc);
    chk("a64_latency", 513'(cyc), 513'(1));
    drain();
    chk("a64_w0",  513'(last_blk[31:0]),    513'(32'h00000080));
    chk("a64_w14", 513'(last_blk[479:448]), 513'(32'h00000200));

    // Backpressure: hold ready low for 5 cycles while offering a byte
    bp_mode = 2;
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg, 1, 0);
    wait_valid(cyc);
    snap = cur_blk();
    for (int i = 0; i < 5; i++) begin
      s_data_i = 8'hEE; s_last_i = 1'b1; s_valid_i = 1'b1;
      @(negedge clk);
      chk("bp_s_ready",   513'(s_ready_o),   513'(0));
      chk("bp_blk_valid", 513'(blk_valid_o), 513'(1));
      chk("bp_blk_hold",  cur_blk(),         snap);
    end
    s_valid_i = 1'b0; s_last_i = 1'b0;
    bp_mode = 0;
    drain();
    chk("bp_blk_same", last_blk, abc_blk);

    // Reset mid-message, then "abc"
    msg.delete();
    for (int i = 0; i < 10; i++) msg.push_back(8'($urandom_range(0, 255)));
    send_msg(msg, 0, 0);
    do_reset();
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg, 1, 0);
    wait_valid(cyc);
    chk("rstmid_latency", 513'(cyc), 513'(3));
    drain();
    chk("rstmid_blk", last_blk, abc_blk);

    // Back-to-back "a" then "bc"
    msg = '{8'h61};
    send_msg(msg, 1, 0);
    msg = '{8'h62, 8'h63};
    send_msg(msg, 1, 0);
    drain();
    chk("b2b_w0",  513'(last_blk[31:0]),    513'(32'h00806362));
    chk("b2b_w14", 513'(last_blk[479:448]), 513'(32'h00000010));

    // Random messages with random gaps and random backpressure
    bp_mode = 1;
    for (int m = 0; m < 10; m++) begin
      msg.delete();
      for (int i = 0; i < $urandom_range(1, 140); i++) msg.push_back(8'($urandom_range(0, 255)));
      send_msg(msg, 1, 2);
    end
    drain();
    bp_mode = 0;
    repeat (4) @(negedge clk);
    chk("end_state", 513'(st_o), 513'(ST_FILL));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
